// File: rtl/fxp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : fxp_pkg                                                        |
// | Purpose : Shared fixed-point definitions. It holds the sample typedef    |
// |           and the overlap-add serializer FSM state encoding.            |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package fxp_pkg;

  // Default sample format. Parameterised blocks size their own vectors.
  localparam int FXP_SIZE_DEFAULT  = 16;
  localparam int FRAC_SIZE_DEFAULT = 12;

  typedef logic signed [FXP_SIZE_DEFAULT-1:0] fxp_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } ola_state_e;

endpackage : fxp_pkg
`default_nettype wire

// File: rtl/overlap_add_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : overlap_add_serializer_if                                    |
// | Purpose   : Block input / serial output bundle of the serializer.        |
// | Signals   : i_data    block of BLOCK_SIZE+TAIL_SIZE samples (elem 0 first)|
// |             i_valid   single-cycle strobe announcing a new block         |
// |             i_pop     consumer takes o_data this cycle                   |
// |             o_data    current output sample                              |
// |             o_valid   o_data holds an unconsumed sample                  |
// |             o_overrun sticky: a block arrived while still draining       |
// | Modports  : master (producer/consumer side), slave (serializer side)     |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface overlap_add_serializer_if #(
  parameter int FXP_SIZE   = 16,
  parameter int BLOCK_SIZE = 16,
  parameter int TAIL_SIZE  = 16
);
  logic [BLOCK_SIZE+TAIL_SIZE-1:0][FXP_SIZE-1:0] i_data;
  logic                                          i_valid;
  logic                                          i_pop;
  logic [FXP_SIZE-1:0]                           o_data;
  logic                                          o_valid;
  logic                                          o_overrun;

  modport master (
    output i_data, i_valid, i_pop,
    input  o_data, o_valid, o_overrun
  );

  modport slave (
    input  i_data, i_valid, i_pop,
    output o_data, o_valid, o_overrun
  );
endinterface : overlap_add_serializer_if
`default_nettype wire

// File: rtl/fxp_sat_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fxp_sat_add                                                    |
// | Purpose : Two's complement adder for one overlap lane.                   |
// |           With OLA_SATURATE_EN defined the result clamps to the most     |
// |           positive / most negative value; otherwise it wraps.            |
// | Ports   : i_a, i_b  addends (FXP_SIZE bits, signed)                      |
// |           o_sum     result  (FXP_SIZE bits, signed)                      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module fxp_sat_add #(
  parameter int FXP_SIZE = 16
) (
  input  wire logic [FXP_SIZE-1:0] i_a,
  input  wire logic [FXP_SIZE-1:0] i_b,
  output logic      [FXP_SIZE-1:0] o_sum
);

  // One guard bit: overflow shows up as guard != MSB of the result.
  logic [FXP_SIZE:0] w_wide;
  assign w_wide = {i_a[FXP_SIZE-1], i_a} + {i_b[FXP_SIZE-1], i_b};

`ifdef OLA_SATURATE_EN
  always_comb begin
    o_sum = w_wide[FXP_SIZE-1:0];
    if (w_wide[FXP_SIZE] != w_wide[FXP_SIZE-1]) begin
      // Guard bit carries the true sign of the overflowed sum.
      o_sum = w_wide[FXP_SIZE] ? {1'b1, {(FXP_SIZE-1){1'b0}}}
                               : {1'b0, {(FXP_SIZE-1){1'b1}}};
    end
  end
`else
  logic w_unused_guard;
  assign w_unused_guard = w_wide[FXP_SIZE];
  assign o_sum          = w_wide[FXP_SIZE-1:0];
`endif

endmodule : fxp_sat_add
`default_nettype wire

// File: rtl/overlap_add_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : overlap_add_serializer                                         |
// | Purpose : Overlap-add a convolved block with the stored tail of the      |
// |           previous block and stream the BLOCK_SIZE results out one       |
// |           sample per pop. Optional saturation: OLA_SATURATE_EN.          |
// | Ports   : clk  clock, rising edge                                        |
// |           rst  asynchronous, active-low reset                            |
// |           bus  overlap_add_serializer_if.slave (block in, samples out)   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module overlap_add_serializer
  import fxp_pkg::*;
#(
  parameter int FXP_SIZE   = 16,
  parameter int FRAC_SIZE  = 12,
  parameter int BLOCK_SIZE = 16,
  parameter int TAIL_SIZE  = 16
) (
  input wire logic                  clk,
  input wire logic                  rst,
  overlap_add_serializer_if.slave   bus
);

  localparam int                IDX_W    = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int                TAIL_W   = (TAIL_SIZE > 0) ? TAIL_SIZE : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  // FRAC_SIZE only documents the sample format; this guard keeps it referenced.
  if (FRAC_SIZE > FXP_SIZE) begin : g_frac_out_of_range
  end

  ola_state_e                               state_q, state_d;
  logic [IDX_W-1:0]                         idx_q, idx_d;
  logic [BLOCK_SIZE-1:0][FXP_SIZE-1:0]      buf_q, buf_d;
  logic [TAIL_W-1:0][FXP_SIZE-1:0]          tail_q, tail_d;
  logic [FXP_SIZE-1:0]                      o_data_q, o_data_d;
  logic                                     overrun_q, overrun_d;

  logic [BLOCK_SIZE-1:0][FXP_SIZE-1:0]      w_sum;
  logic [IDX_W-1:0]                         w_idx_nxt;
  logic                                     w_pop;
  logic                                     w_last;
  logic                                     w_accept;

  // Head of the new block overlapped with the stored tail, lane by lane.
  for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_lane
    if (k < TAIL_SIZE) begin : g_add
      fxp_sat_add #(.FXP_SIZE(FXP_SIZE)) u_add (
        .i_a   (bus.i_data[k]),
        .i_b   (tail_q[k]),
        .o_sum (w_sum[k])
      );
    end else begin : g_pass
      assign w_sum[k] = bus.i_data[k];
    end
  end

  assign w_pop     = bus.i_pop && (state_q == ST_DRAIN);
  assign w_last    = (idx_q == LAST_IDX);
  assign w_idx_nxt = idx_q + 1'b1;
  // A new block is taken when idle, or seamlessly on the pop of the last sample.
  assign w_accept  = bus.i_valid && ((state_q == ST_IDLE) || (w_pop && w_last));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    tail_d    = tail_q;
    o_data_d  = o_data_q;
    overrun_d = overrun_q;
    if (w_accept) begin
      state_d  = ST_DRAIN;
      idx_d    = '0;
      buf_d    = w_sum;
      o_data_d = w_sum[0];
      for (int k = 0; k < TAIL_SIZE; k++) begin
        tail_d[k] = bus.i_data[BLOCK_SIZE + k];
      end
    end else begin
      if (bus.i_valid && (state_q == ST_DRAIN)) begin
        overrun_d = 1'b1;  // block dropped, sticky until reset
      end
      if (w_pop) begin
        if (w_last) begin
          state_d = ST_IDLE;   // o_data keeps the last sample
          idx_d   = '0;
        end else begin
          idx_d    = w_idx_nxt;
          o_data_d = buf_q[w_idx_nxt];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      buf_q     <= '0;
      tail_q    <= '0;
      o_data_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      tail_q    <= tail_d;
      o_data_q  <= o_data_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.o_data    = o_data_q;
  assign bus.o_valid   = (state_q == ST_DRAIN);
  assign bus.o_overrun = overrun_q;

endmodule : overlap_add_serializer
`default_nettype wire

// File: tb/tb_overlap_add_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_overlap_add_serializer                                      |
// | Purpose : Directed self-checking bench for overlap_add_serializer with   |
// |           BLOCK_SIZE = TAIL_SIZE = 4, 16-bit samples. Expected values    |
// |           follow OLA_SATURATE_EN when it is defined.                     |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_overlap_add_serializer;
  import fxp_pkg::*;

  localparam int FXP = 16;
  localparam int BLK = 4;
  localparam int TL  = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  overlap_add_serializer_if #(.FXP_SIZE(FXP), .BLOCK_SIZE(BLK), .TAIL_SIZE(TL)) bus ();

  overlap_add_serializer #(
    .FXP_SIZE  (FXP),
    .FRAC_SIZE (12),
    .BLOCK_SIZE(BLK),
    .TAIL_SIZE (TL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a block (head h*, tail t*) with i_valid raised; caller clocks it.
  task automatic load(input fxp_t h0, input fxp_t h1, input fxp_t h2, input fxp_t h3,
                      input fxp_t t0, input fxp_t t1, input fxp_t t2, input fxp_t t3);
    bus.i_data[0] = h0; bus.i_data[1] = h1; bus.i_data[2] = h2; bus.i_data[3] = h3;
    bus.i_data[4] = t0; bus.i_data[5] = t1; bus.i_data[6] = t2; bus.i_data[7] = t3;
    bus.i_valid   = 1'b1;
  endtask

  // Check the presented sample, then consume it.
  task automatic pop_check(input string tag, input logic [15:0] exp);
    chk({tag, "_valid"}, {15'd0, bus.o_valid}, 16'd1);
    chk(tag, bus.o_data, exp);
    bus.i_pop = 1'b1;
    tick();
    bus.i_pop = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b0;
    bus.i_data  = '0;
    bus.i_valid = 1'b0;
    bus.i_pop   = 1'b0;
    repeat (2) tick();
    chk("rst_valid",   {15'd0, bus.o_valid},   16'd0);
    chk("rst_data",    bus.o_data,             16'h0000);
    chk("rst_overrun", {15'd0, bus.o_overrun}, 16'd0);
    rst = 1'b1;
    tick();

    // Two uniform blocks; the second arrives on the last pop of the first.
    load(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    tick();
    bus.i_valid = 1'b0;
    pop_check("a0", 16'h0100);
    pop_check("a1", 16'h0100);
    pop_check("a2", 16'h0100);
    load(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
    pop_check("a3", 16'h0100);
    bus.i_valid = 1'b0;
    chk("chain_overrun", {15'd0, bus.o_overrun}, 16'd0);
    pop_check("b0", 16'h0200);
    pop_check("b1", 16'h0200);
    pop_check("b2", 16'h0200);
    pop_check("b3", 16'h0200);
    chk("b_idle_valid", {15'd0, bus.o_valid}, 16'd0);
    chk("b_hold_data",  bus.o_data,           16'h0200);

    // Pops while idle must be ignored.
    bus.i_pop = 1'b1;
    tick();
    bus.i_pop = 1'b0;
    chk("idle_pop_valid", {15'd0, bus.o_valid}, 16'd0);
    chk("idle_pop_data",  bus.o_data,           16'h0200);

    // Zero head over the 0x0100 tail; leaves overflow-prone tail behind.
    load(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7000, 16'h9000, 16'h0005, 16'hFFFF);
    tick();
    bus.i_valid = 1'b0;
    pop_check("c0", 16'h0100);
    pop_check("c1", 16'h0100);
    pop_check("c2", 16'h0100);
    pop_check("c3", 16'h0100);

    // Overlap additions at the positive and negative limits.
    load(16'h7000, 16'h9000, 16'h0003, 16'h0002, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    tick();
    bus.i_valid = 1'b0;
`ifdef OLA_SATURATE_EN
    pop_check("d0_pos_limit", 16'h7FFF);
    pop_check("d1_neg_limit", 16'h8000);
`else
    pop_check("d0_pos_limit", 16'hE000);
    pop_check("d1_neg_limit", 16'h2000);
`endif
    pop_check("d2", 16'h0008);
    pop_check("d3", 16'h0001);

    // Block arriving mid-drain is dropped and flags overrun.
    load(16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00);
    tick();
    bus.i_valid = 1'b0;
    pop_check("e0", 16'h1011);
    pop_check("e1", 16'h2022);
    load(16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555, 16'h5555);
    tick();
    bus.i_valid = 1'b0;
    chk("ovr_set", {15'd0, bus.o_overrun}, 16'd1);
    pop_check("e2", 16'h3033);
    pop_check("e3", 16'h4044);
    chk("ovr_sticky", {15'd0, bus.o_overrun}, 16'd1);

    // Next block still overlaps with block E's tail.
    load(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0777, 16'h0777, 16'h0777, 16'h0777);
    tick();
    bus.i_valid = 1'b0;
    pop_check("g0", 16'h0A00);
    chk("g1_pre_rst", bus.o_data, 16'h0B00);

    // Asynchronous reset at index 1.
    rst = 1'b0;
    #1;
    chk("mid_rst_valid",   {15'd0, bus.o_valid},   16'd0);
    chk("mid_rst_data",    bus.o_data,             16'h0000);
    chk("mid_rst_overrun", {15'd0, bus.o_overrun}, 16'd0);
    tick();
    rst = 1'b1;
    tick();

    // First block after reset overlaps with zeros.
    load(16'h0123, 16'h0456, 16'h0789, 16'h0ABC, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    tick();
    bus.i_valid = 1'b0;
    pop_check("h0", 16'h0123);
    pop_check("h1", 16'h0456);
    pop_check("h2", 16'h0789);
    pop_check("h3", 16'h0ABC);
    chk("h_idle_valid", {15'd0, bus.o_valid}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_overlap_add_serializer
`default_nettype wire
